alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Execute-stage controller that sequences the shared ALU. Accepts one decoded operation at a time from decode over a valid/ready handshake and drives the ALU's enable, opcode and operands. Counts out the operation's latency, captures the ALU result into a holding register, and presents it to the memory stage over a second valid/ready handshake. Single-issue, non-pipelined; flush support for branch recovery.

## Interface
- TAG_W, 4: width of the instruction tag carried alongside each op
- MUL_LAT, 3: ALU latency in cycles for MUL-class opcodes (≥1)
- DIV_LAT, 16: ALU latency in cycles for DIV-class opcodes (≥1)

- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of in-flight and held ops
- in_valid  in  1  decode presents an op
- in_ready  out  1  controller accepts this cycle
- in_opcode  in  opcode_t  operation
- in_oprd1/in_oprd2/in_oprd3  in  64 each  operands
- in_tag  in  TAG_W  instruction tag
- alu_enable  out  1  one-cycle issue pulse to the ALU
- alu_opcode  out  opcode_t  opcode held to the ALU
- alu_oprd1/alu_oprd2/alu_oprd3  out  64 each  operands held to the ALU
- alu_result  in  128  ALU result register
- alu_flags  in  64  ALU flags
- out_valid  out  1  result available to the memory stage
- out_ready  in  1  memory stage consumes
- out_result  out  128  captured result
- out_flags  out  64  captured flags
- out_tag  out  TAG_W  tag of the captured op
- busy  out  1  state ≠ IDLE or out_valid

## Operation
- States: IDLE, ISSUE, WAIT.
- in_ready = (state==IDLE) && !flush && (!out_valid || out_ready).
- IDLE: on in_valid && in_ready, register opcode, operands and tag; load cnt = L−1, where L is the op's latency; go to ISSUE.
- ISSUE: alu_enable=1 for exactly this cycle; go to WAIT.
- WAIT: if cnt≠0, decrement. If cnt==0, capture alu_result, alu_flags and the held tag into the out regs, set out_valid, and go to IDLE.
- alu_opcode and alu_oprd* stay stable from ISSUE through the end of WAIT. Outside these states they hold their last value.
- The ALU result register updates every clock regardless of enable, so capture must happen exactly on the cnt==0 WAIT cycle.
- out_valid clears on out_ready. Out regs are stable while out_valid && !out_ready.
- A new accept is allowed in the same cycle out_valid drains. It is never allowed while an undrained result is held.
- flush, any state: next state IDLE, out_valid←0, cnt←0, no alu_enable next cycle. flush outranks accept and capture in the same cycle.
- Reset (async, reset_n=0): state IDLE, cnt 0, and every output 0 (including in_ready, alu_*, out_*, busy). in_ready rises on the first cycle after release.

## Timing
- Accept at cycle T: alu_enable high at T+1.
- Capture at the end of cycle T+1+L; out_valid high from T+2+L.
- Single-cycle op: out_valid at T+3. Next accept is possible at T+3 if out_ready=1 then.
- in_ready and busy are combinational from state, out_valid, out_ready and flush. All other outputs are registered.

## Configuration
- ALU_MULTICYCLE_EN defined: L=MUL_LAT for MUL-class opcodes, L=DIV_LAT for DIV-class opcodes, L=1 otherwise.
- ALU_MULTICYCLE_EN undefined: L=1 for every opcode. The class decode and MUL_LAT/DIV_LAT are unused, and cnt reduces to a single WAIT cycle.

## Structure
- Shared package with instruction.svh:
  - lat_class_t enum {LAT_SINGLE, LAT_MUL, LAT_DIV}
  - function alu_lat_class(opcode_t)
  - the issue-state enum
- Sub-module alu_lat_counter: loadable down-counter with a zero flag, sized $clog2(max(MUL_LAT,DIV_LAT)+1).

## Test plan
- Reset mid-WAIT of a DIV: assert reset_n=0 → all outputs 0 immediately; after release, in_ready=1 and no stale out_valid.
- ADD with oprd1=5, oprd2=7, tag=3, accepted at T, out_ready=1 → one alu_enable pulse at T+1; out_valid at T+3 with out_result=12 and out_tag=3.
- With ALU_MULTICYCLE_EN, MUL accepted at T, MUL_LAT=3 → out_valid at T+5. in_ready=0 during T+1..T+4.
- out_ready=0 for 10 cycles after a result → out_result and out_tag stable, in_ready=0. Raise out_ready with in_valid=1 → drain and accept in the same cycle.
- flush during WAIT of a DIV, and flush while out_valid=1 → out_valid=0 next cycle, no capture, and in_ready=1 the cycle after flush deasserts.
- Back-to-back single-cycle ops with constant in_valid=1 and out_ready=1 → one accept every 3 cycles, tags delivered in order.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: shared opcode, latency-class and issue-state types for the execute-stage controller
//   opcode_t      : decoded ALU operation
//   lat_class_t   : latency class of an opcode (single / MUL / DIV)
//   issue_state_t : controller FSM states
package alu_issue_ctrl_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_MUL, OP_MULH, OP_DIV, OP_REM
  } opcode_t;
  typedef enum logic [1:0] {LAT_SINGLE, LAT_MUL, LAT_DIV} lat_class_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} issue_state_t;
  function automatic lat_class_t alu_lat_class(opcode_t op);
    return op inside {OP_MUL, OP_MULH} ? LAT_MUL : op inside {OP_DIV, OP_REM} ? LAT_DIV : LAT_SINGLE;
  endfunction
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: decode->controller, controller<->ALU and controller->memory-stage signals
//   master : the controller (alu_issue_ctrl)
//   slave  : the surrounding pipeline (decode, ALU, memory stage)
interface alu_issue_ctrl_if import alu_issue_ctrl_pkg::*; #(parameter int TAG_W = 4) ();
  logic              in_valid, in_ready;
  opcode_t           in_opcode;
  logic [63:0]       in_oprd1, in_oprd2, in_oprd3;
  logic [TAG_W-1:0]  in_tag;
  logic              alu_enable;
  opcode_t           alu_opcode;
  logic [63:0]       alu_oprd1, alu_oprd2, alu_oprd3;
  logic [127:0]      alu_result;
  logic [63:0]       alu_flags;
  logic              out_valid, out_ready;
  logic [127:0]      out_result;
  logic [63:0]       out_flags;
  logic [TAG_W-1:0]  out_tag;
  modport master (
    input  in_valid, in_opcode, in_oprd1, in_oprd2, in_oprd3, in_tag, alu_result, alu_flags, out_ready,
    output in_ready, alu_enable, alu_opcode, alu_oprd1, alu_oprd2, alu_oprd3, out_valid, out_result, out_flags, out_tag
  );
  modport slave (
    output in_valid, in_opcode, in_oprd1, in_oprd2, in_oprd3, in_tag, alu_result, alu_flags, out_ready,
    input  in_ready, alu_enable, alu_opcode, alu_oprd1, alu_oprd2, alu_oprd3, out_valid, out_result, out_flags, out_tag
  );
endinterface

// File: rtl/alu_issue_ctrl_lat_counter.sv
// alu_lat_counter: loadable down-counter with zero flag, counts out the remaining WAIT cycles
//   clr_i clears, load_i loads load_val_i, dec_i decrements (saturating at zero), zero_o flags cnt==0
module alu_lat_counter #(parameter int W = 5) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign zero_o = cnt_q == '0;
  always_comb cnt_d = clr_i ? '0 : load_i ? load_val_i : (dec_i && !zero_o) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-issue execute-stage controller sequencing the shared ALU
//   clk, reset_n (async active-low), flush (sync squash), busy (state!=IDLE or result held)
//   bus (master): decode handshake in_*, ALU drive alu_*, memory-stage handshake out_*
//   ALU_MULTICYCLE_EN: when defined, MUL/DIV-class ops use MUL_LAT/DIV_LAT cycles; otherwise every op takes 1
module alu_issue_ctrl import alu_issue_ctrl_pkg::*; #(
  parameter int TAG_W   = 4,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  output logic             busy,
  alu_issue_ctrl_if.master bus
);
  localparam int MAX_LAT = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
  localparam int CW = $clog2(MAX_LAT + 1);
  issue_state_t     state_q;
  logic             alu_en_q, out_valid_q, cnt_zero, accept;
  opcode_t          op_q;
  logic [63:0]      oprd1_q, oprd2_q, oprd3_q, flags_q;
  logic [127:0]     result_q;
  logic [TAG_W-1:0] tag_q, out_tag_q;
  logic [CW-1:0]    lat_m1;
`ifdef ALU_MULTICYCLE_EN
  assign lat_m1 = alu_lat_class(bus.in_opcode) == LAT_MUL ? CW'(MUL_LAT - 1) :
                  alu_lat_class(bus.in_opcode) == LAT_DIV ? CW'(DIV_LAT - 1) : '0;
`else
  assign lat_m1 = '0;
`endif
  // reset_n gates in_ready so every output reads 0 while reset is held
  assign bus.in_ready   = reset_n && state_q == IDLE && !flush && (!out_valid_q || bus.out_ready);
  assign accept         = bus.in_valid && bus.in_ready;
  assign busy           = state_q != IDLE || out_valid_q;
  assign bus.alu_enable = alu_en_q;
  assign bus.alu_opcode = op_q;
  assign bus.alu_oprd1  = oprd1_q;
  assign bus.alu_oprd2  = oprd2_q;
  assign bus.alu_oprd3  = oprd3_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_q;
  assign bus.out_flags  = flags_q;
  assign bus.out_tag    = out_tag_q;
  alu_lat_counter #(.W(CW)) u_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (flush),
    .load_i     (accept),
    .dec_i      (state_q == WAIT),
    .load_val_i (lat_m1),
    .zero_o     (cnt_zero)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q     <= IDLE;
      alu_en_q    <= 1'b0;
      op_q        <= OP_ADD;
      oprd1_q     <= '0;
      oprd2_q     <= '0;
      oprd3_q     <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      out_tag_q   <= '0;
    end else begin
      // accept already excludes flush, so the issue pulse never follows a flushed cycle
      alu_en_q <= accept;
      if (bus.out_ready) out_valid_q <= 1'b0;
      if (flush) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
      end else case (state_q)
        IDLE: if (accept) begin
          state_q <= ISSUE;
          op_q    <= bus.in_opcode;
          oprd1_q <= bus.in_oprd1;
          oprd2_q <= bus.in_oprd2;
          oprd3_q <= bus.in_oprd3;
          tag_q   <= bus.in_tag;
        end
        ISSUE: state_q <= WAIT;
        WAIT: if (cnt_zero) begin
          // the ALU result register is free-running, so this cycle is the only valid capture point
          state_q     <= IDLE;
          out_valid_q <= 1'b1;
          result_q    <= bus.alu_result;
          flags_q     <= bus.alu_flags;
          out_tag_q   <= tag_q;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed + randomized bench for alu_issue_ctrl with a cycle-level reference model
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;
  localparam int TAG_W = 4, MUL_LAT = 3, DIV_LAT = 16;
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [127:0]     res;
    logic [63:0]      fl;
    opcode_t          op;
    logic [63:0]      a;
  } item_t;
  logic clk = 1'b0, reset_n = 1'b0, flush = 1'b0, busy;
  int checks = 0, errors = 0;
  item_t pend, held_it;
  bit inflight = 0, held = 0, acc = 0;
  int cyc_n = 0, due = 0, en_cyc = -1, dut_acc = 0, rem = 0, a0 = 0;
  logic [TAG_W-1:0] tg;
  alu_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();
  alu_issue_ctrl #(.TAG_W(TAG_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .busy(busy), .bus(bus.master)
  );
  always #5 clk = ~clk;
  function automatic int lat_of(opcode_t op);
`ifdef ALU_MULTICYCLE_EN
    return op inside {OP_MUL, OP_MULH} ? MUL_LAT : op inside {OP_DIV, OP_REM} ? DIV_LAT : 1;
`else
    return 1;
`endif
  endfunction
  function automatic logic [127:0] alu_res(opcode_t op, logic [63:0] a, logic [63:0] b, logic [63:0] c);
    case (op)
      OP_ADD:          return 128'(a + b);
      OP_SUB:          return 128'(a - b);
      OP_MUL, OP_MULH: return {64'b0, a} * {64'b0, b};
      OP_DIV, OP_REM:  return b == '0 ? '1 : 128'(a / b);
      default:         return {c, a ^ b};
    endcase
  endfunction
  function automatic logic [63:0] alu_flg(opcode_t op, logic [63:0] a, logic [63:0] c);
    return a ^ c ^ 64'(op);
  endfunction
  // ALU stand-in: result register is garbage except on the cycle L cycles after the issue pulse
  always @(posedge clk) begin
    if (bus.alu_enable) rem = lat_of(bus.alu_opcode);
    bus.alu_result <= rem == 1 ? alu_res(bus.alu_opcode, bus.alu_oprd1, bus.alu_oprd2, bus.alu_oprd3)
                               : {$urandom, $urandom, $urandom, $urandom};
    bus.alu_flags  <= rem == 1 ? alu_flg(bus.alu_opcode, bus.alu_oprd1, bus.alu_oprd3) : {$urandom, $urandom};
    if (rem > 0) rem--;
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input bit v, input opcode_t op, input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] t);
    bus.in_valid  = v;
    bus.in_opcode = op;
    bus.in_oprd1  = a;
    bus.in_oprd2  = b;
    bus.in_oprd3  = a ^ {b[31:0], b[63:32]};
    bus.in_tag    = t;
  endtask
  // one clock: check mid-cycle against the model, then advance the model at the edge
  task automatic cyc();
    @(negedge clk);
    acc = bus.in_valid && !inflight && !flush && (!held || bus.out_ready);
    chk("in_ready", bus.in_ready, !inflight && !flush && (!held || bus.out_ready));
    chk("out_valid", bus.out_valid, held);
    chk("busy", busy, inflight || held);
    chk("alu_enable", bus.alu_enable, cyc_n == en_cyc);
    if (held) begin
      chk("out_tag", bus.out_tag, held_it.tag);
      chk("out_result", bus.out_result, held_it.res);
      chk("out_flags", bus.out_flags, held_it.fl);
    end
    if (inflight) begin
      chk("alu_opcode", bus.alu_opcode, pend.op);
      chk("alu_oprd1", bus.alu_oprd1, pend.a);
    end
    if (bus.in_valid && bus.in_ready) dut_acc++;
    @(posedge clk);
    if (flush) begin
      inflight = 0;
      held = 0;
    end else begin
      if (held && bus.out_ready) held = 0;
      if (inflight && cyc_n == due - 1) begin
        held = 1;
        held_it = pend;
        inflight = 0;
      end
      if (acc) begin
        inflight = 1;
        due = cyc_n + 2 + lat_of(bus.in_opcode);
        en_cyc = cyc_n + 1;
        pend.tag = bus.in_tag;
        pend.op = bus.in_opcode;
        pend.a = bus.in_oprd1;
        pend.res = alu_res(bus.in_opcode, bus.in_oprd1, bus.in_oprd2, bus.in_oprd3);
        pend.fl = alu_flg(bus.in_opcode, bus.in_oprd1, bus.in_oprd3);
      end
    end
    cyc_n++;
    #1;
  endtask
  initial begin
    drive(0, OP_ADD, '0, '0, '0);
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", bus.in_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst alu_enable", bus.alu_enable, 0);
    chk("rst alu_opcode", bus.alu_opcode, 0);
    chk("rst alu_oprd1", bus.alu_oprd1, 0);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst out_result", bus.out_result, 0);
    chk("rst out_tag", bus.out_tag, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("release in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    // ADD 5+7 tag 3: pulse at T+1, result at T+3
    bus.out_ready = 1'b1;
    drive(1, OP_ADD, 64'd5, 64'd7, 4'd3);
    cyc();
    drive(0, OP_ADD, '0, '0, '0);
    chk("add enable T+1", bus.alu_enable, 1);
    cyc();
    chk("add enable T+2", bus.alu_enable, 0);
    chk("add no valid T+2", bus.out_valid, 0);
    cyc();
    chk("add valid T+3", bus.out_valid, 1);
    chk("add result", bus.out_result, 128'd12);
    chk("add tag", bus.out_tag, 3);
    cyc();
    // MUL: timing per configured latency
    drive(1, OP_MUL, 64'd6, 64'd7, 4'd5);
    cyc();
    drive(0, OP_ADD, '0, '0, '0);
    repeat (7) cyc();
    // memory stage stalls with a result held, then drain and accept together
    bus.out_ready = 1'b0;
    drive(1, OP_ADD, 64'd100, 64'd23, 4'd9);
    cyc();
    drive(0, OP_ADD, '0, '0, '0);
    repeat (12) cyc();
    chk("stall tag", bus.out_tag, 9);
    chk("stall result", bus.out_result, 128'd123);
    drive(1, OP_SUB, 64'd50, 64'd8, 4'd10);
    bus.out_ready = 1'b1;
    a0 = dut_acc;
    cyc();
    chk("drain+accept", dut_acc - a0, 1);
    drive(0, OP_ADD, '0, '0, '0);
    repeat (4) cyc();
    // flush in the WAIT of a DIV
    drive(1, OP_DIV, 64'd100, 64'd7, 4'd11);
    cyc();
    drive(0, OP_ADD, '0, '0, '0);
    repeat (2) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush wait no valid", bus.out_valid, 0);
    repeat (20) cyc();
    // flush while a result is held
    bus.out_ready = 1'b0;
    drive(1, OP_XOR, 64'hF0, 64'h0F, 4'd12);
    cyc();
    drive(0, OP_ADD, '0, '0, '0);
    repeat (3) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush held no valid", bus.out_valid, 0);
    cyc();
    // back-to-back single-cycle ops: one accept every 3 cycles
    bus.out_ready = 1'b1;
    tg = 4'd1;
    a0 = dut_acc;
    for (int i = 0; i < 12; i++) begin
      drive(1, OP_ADD, 64'(i), 64'(i + 1), tg);
      cyc();
      if (acc) tg = tg + 1'b1;
    end
    chk("b2b accepts", dut_acc - a0, 4);
    drive(0, OP_ADD, '0, '0, '0);
    repeat (4) cyc();
    // async reset in the WAIT of a DIV
    drive(1, OP_DIV, 64'd999, 64'd3, 4'd13);
    cyc();
    drive(0, OP_ADD, '0, '0, '0);
    cyc();
    #2 reset_n = 1'b0;
    #1;
    chk("mid rst out_valid", bus.out_valid, 0);
    chk("mid rst alu_enable", bus.alu_enable, 0);
    chk("mid rst alu_oprd1", bus.alu_oprd1, 0);
    chk("mid rst alu_opcode", bus.alu_opcode, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst in_ready", bus.in_ready, 0);
    inflight = 0;
    held = 0;
    en_cyc = -1;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("mid release in_ready", bus.in_ready, 1);
    chk("mid release out_valid", bus.out_valid, 0);
    @(posedge clk);
    cyc_n++;
    #1;
    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      flush = $urandom_range(0, 99) < 3;
      bus.out_ready = $urandom_range(0, 9) < 6;
      drive($urandom_range(0, 9) < 7, opcode_t'($urandom_range(0, 11)), {$urandom, $urandom}, {$urandom, $urandom}, TAG_W'($urandom));
      cyc();
    end
    flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(0, OP_ADD, '0, '0, '0);
    repeat (40) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
